// File: rtl/sprite_palette_ram.sv
// Banked sprite colour palette: register-array storage, per-frame bank switching,
// and a 2-stage lookup pipeline with a brightness (dim) shift.
module sprite_palette_ram #(
  parameter  int INDEX_W   = 4,
  parameter  int NUM_BANKS = 4,
  parameter  int COLOR_W   = 4,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_start,
  input  logic [BANK_W-1:0]      bank_req,
  input  logic [1:0]             dim,
  input  logic                   rd_valid,
  input  logic [INDEX_W-1:0]     rd_index,
  input  logic                   wr_en,
  input  logic [BANK_W-1:0]      wr_bank,
  input  logic [INDEX_W-1:0]     wr_index,
  input  logic [3*COLOR_W-1:0]   wr_data,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   transparent,
  output logic                   out_valid,
  output logic [BANK_W-1:0]      active_bank
);

  localparam int ENTRIES = 2 ** INDEX_W;
  localparam int ENTRY_W = 3 * COLOR_W;
  localparam logic [BANK_W:0] NUM_BANKS_L = (BANK_W + 1)'(NUM_BANKS);

  // Grayscale ramp value restored into every bank on reset.
  function automatic logic [ENTRY_W-1:0] ramp_entry(input int idx);
    logic [COLOR_W-1:0] c;
    c = COLOR_W'(idx);
    return {c, c, c};
  endfunction

  logic [ENTRY_W-1:0] r_mem [NUM_BANKS][ENTRIES];
  logic [BANK_W-1:0]  r_bank_pend;
  logic [BANK_W-1:0]  r_active_bank;

  logic               r_s1_valid;
  logic [INDEX_W-1:0] r_s1_index;
  logic [1:0]         r_s1_dim;
  logic [ENTRY_W-1:0] r_s1_entry;

  logic               r_valid;
  logic [COLOR_W-1:0] r_red;
  logic [COLOR_W-1:0] r_green;
  logic [COLOR_W-1:0] r_blue;
  logic               r_transp;

  logic               w_wr_ok;
  logic [BANK_W-1:0]  w_bank_cand;
  logic               w_bank_ok;
  logic [COLOR_W-1:0] w_red;
  logic [COLOR_W-1:0] w_green;
  logic [COLOR_W-1:0] w_blue;
  logic               w_transp;

  assign w_wr_ok     = wr_en && ({1'b0, wr_bank} < NUM_BANKS_L);
  // The bank request sampled on the boundary cycle itself wins over the pending copy.
  assign w_bank_cand = frame_start ? bank_req : r_bank_pend;
  assign w_bank_ok   = {1'b0, w_bank_cand} < NUM_BANKS_L;

  // Palette storage: ramp on reset, single write port.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int i = 0; i < ENTRIES; i++) begin
          r_mem[b][i] <= ramp_entry(i);
        end
      end
    end else if (w_wr_ok) begin
      r_mem[wr_bank][wr_index] <= wr_data;
    end
  end

  // Pending and active bank registers; out-of-range requests are ignored.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_bank_pend   <= '0;
      r_active_bank <= '0;
    end else begin
      if (!frame_start) begin
        r_bank_pend <= bank_req;
      end
      if (frame_start && w_bank_ok) begin
        r_active_bank <= w_bank_cand;
      end
    end
  end

  // Stage 1: capture request and the entry as stored before any same-cycle write.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s1_valid <= 1'b0;
      r_s1_index <= '0;
      r_s1_dim   <= 2'd0;
      r_s1_entry <= '0;
    end else begin
      r_s1_valid <= rd_valid;
      r_s1_index <= rd_index;
      r_s1_dim   <= dim;
      r_s1_entry <= r_mem[r_active_bank][rd_index];
    end
  end

  // Stage-2 next values: dimmed channels and flag, forced to zero when idle.
  always_comb begin
    w_red    = '0;
    w_green  = '0;
    w_blue   = '0;
    w_transp = 1'b0;
    if (r_s1_valid) begin
      w_red    = r_s1_entry[ENTRY_W-1 -: COLOR_W] >> r_s1_dim;
      w_green  = r_s1_entry[2*COLOR_W-1 -: COLOR_W] >> r_s1_dim;
      w_blue   = r_s1_entry[COLOR_W-1:0] >> r_s1_dim;
      w_transp = (r_s1_index == '0);
    end else begin
      w_red    = '0;
      w_green  = '0;
      w_blue   = '0;
      w_transp = 1'b0;
    end
  end

  // Stage 2: registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_valid  <= 1'b0;
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
      r_transp <= 1'b0;
    end else begin
      r_valid  <= r_s1_valid;
      r_red    <= w_red;
      r_green  <= w_green;
      r_blue   <= w_blue;
      r_transp <= w_transp;
    end
  end

  assign out_valid   = r_valid;
  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;
  assign transparent = r_transp;
  assign active_bank = r_active_bank;

endmodule

// File: tb/tb_sprite_palette_ram.sv
// Scoreboard bench for sprite_palette_ram: directed scenarios plus random traffic
// checked against an array-based palette model.
module tb_sprite_palette_ram;

  localparam int IW = 4;
  localparam int NB = 3;
  localparam int CW = 4;
  localparam int BW = 2;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          frame_start;
  logic [BW-1:0] bank_req;
  logic [1:0]    dim;
  logic          rd_valid;
  logic [IW-1:0] rd_index;
  logic          wr_en;
  logic [BW-1:0] wr_bank;
  logic [IW-1:0] wr_index;
  logic [11:0]   wr_data;
  logic [3:0]    red, green, blue;
  logic          transparent, out_valid;
  logic [BW-1:0] active_bank;

  sprite_palette_ram #(.INDEX_W(IW), .NUM_BANKS(NB), .COLOR_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .bank_req(bank_req),
    .dim(dim), .rd_valid(rd_valid), .rd_index(rd_index), .wr_en(wr_en),
    .wr_bank(wr_bank), .wr_index(wr_index), .wr_data(wr_data),
    .red(red), .green(green), .blue(blue), .transparent(transparent),
    .out_valid(out_valid), .active_bank(active_bank)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] r, g, b;
    logic       t;
    int         due;
  } exp_t;

  exp_t       sbq[$];
  logic [11:0] m_mem [NB][16];
  int         m_active;
  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < 16; i++)
        m_mem[b][i] = {3{4'(i % 16)}};
    m_active = 0;
    sbq.delete();
  endtask

  // One clock: predict any lookup from pre-edge state, then apply writes/bank change.
  task automatic tick();
    exp_t e;
    int   v;
    if (rd_valid) begin
      v     = int'(m_mem[m_active][rd_index]);
      e.r   = 4'(((v >> 8) % 16) >> dim);
      e.g   = 4'(((v >> 4) % 16) >> dim);
      e.b   = 4'((v % 16) >> dim);
      e.t   = (rd_index == 0);
      e.due = cyc + 2;
      sbq.push_back(e);
    end
    @(posedge Clk);
    if (wr_en && int'(wr_bank) < NB) m_mem[wr_bank][wr_index] = wr_data;
    if (frame_start && int'(bank_req) < NB) m_active = int'(bank_req);
    #1;
  endtask

  task automatic clr();
    rd_valid = 1'b0; wr_en = 1'b0; frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    clr();
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic rd(input int idx, input int d);
    clr(); rd_valid = 1'b1; rd_index = 4'(idx); dim = 2'(d); tick(); clr();
  endtask

  task automatic wr(input int bk, input int idx, input int data);
    clr(); wr_en = 1'b1; wr_bank = 2'(bk); wr_index = 4'(idx); wr_data = 12'(data); tick(); clr();
  endtask

  task automatic switch_bank(input int bk);
    clr(); bank_req = 2'(bk); frame_start = 1'b1; tick(); clr();
  endtask

  // Monitor: pop on every out_valid; outputs must be zero otherwise.
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      if (out_valid) begin
        checks++;
        if (sbq.size() == 0) begin
          $display("FAIL unexpected_out_valid at cycle %0d: rgb=%h%h%h t=%0d", cyc, red, green, blue, transparent);
        end else begin
          e = sbq.pop_front();
          if (e.due == cyc && red == e.r && green == e.g && blue == e.b && transparent == e.t)
            passes++;
          else
            $display("FAIL lookup: got rgb=%h%h%h t=%0d cycle %0d, expected rgb=%h%h%h t=%0d cycle %0d",
                     red, green, blue, transparent, cyc, e.r, e.g, e.b, e.t, e.due);
        end
      end else begin
        checks++;
        if ({red, green, blue, transparent} == 13'd0) passes++;
        else $display("FAIL idle_outputs_nonzero: got rgb=%h%h%h t=%0d expected 0", red, green, blue, transparent);
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
          e = sbq.pop_front();
          checks++;
          $display("FAIL missing_out_valid: got none at cycle %0d, expected one due %0d", cyc, e.due);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; bank_req = 2'd0; dim = 2'd0; rd_index = 4'd0;
    wr_bank = 2'd0; wr_index = 4'd0; wr_data = 12'd0;
    clr();
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_rgb", int'({red, green, blue}), 0);
    chk("reset_active_bank", int'(active_bank), 0);
    Reset = 1'b0;

    // Ramp readback, dim shifts, read-during-write.
    rd(5, 0);
    idle(2);
    wr(0, 3, 12'hF80);
    rd(3, 1);
    rd(3, 3);
    clr(); wr_en = 1'b1; wr_bank = 2'd0; wr_index = 4'd2; wr_data = 12'hABC;
    rd_valid = 1'b1; rd_index = 4'd2; dim = 2'd0; tick();
    rd(2, 0);
    idle(2);

    // Bank switching at frame boundary.
    wr(1, 1, 12'h123);
    clr(); bank_req = 2'd1; rd_valid = 1'b1; rd_index = 4'd1; dim = 2'd0; tick();
    chk("bank_no_switch_without_frame", int'(active_bank), 0);
    clr(); frame_start = 1'b1; bank_req = 2'd1; rd_valid = 1'b1; rd_index = 4'd1; tick();
    chk("bank_after_frame_start", int'(active_bank), 1);
    rd(1, 0);
    switch_bank(3);
    chk("bank_out_of_range_ignored", int'(active_bank), 1);
    wr(3, 1, 12'hFFF);
    rd(1, 0);

    // Back-to-back sweep of bank 0.
    switch_bank(0);
    chk("bank_back_to_zero", int'(active_bank), 0);
    for (int i = 0; i < 16; i++) begin
      rd_valid = 1'b1; rd_index = 4'(i); dim = 2'd0; tick();
    end
    idle(3);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      rd_valid    = 1'($urandom_range(0, 1));
      rd_index    = 4'($urandom);
      dim         = 2'($urandom);
      wr_en       = 1'($urandom_range(0, 1));
      wr_bank     = 2'($urandom);
      wr_index    = 4'($urandom);
      wr_data     = 12'($urandom);
      bank_req    = 2'($urandom);
      frame_start = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle(3);

    // Reset with two lookups in flight.
    switch_bank(2);
    wr(0, 7, 12'h5A5);
    rd(4, 0);
    rd(6, 1);
    Reset = 1'b1;
    sbq.delete();
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();
    chk("post_reset_active_bank", int'(active_bank), 0);
    idle(5);
    for (int b = 0; b < NB; b++) begin
      switch_bank(b);
      for (int i = 0; i < 16; i++) begin
        rd_valid = 1'b1; rd_index = 4'(i); dim = 2'd0; tick();
      end
      clr();
    end
    idle(4);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
